// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count, select type,
// channel constants and the per-slot state encoding.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t CH0 = 2'd0;
  localparam sel_t CH1 = 2'd1;
  localparam sel_t CH2 = 2'd2;
  localparam sel_t CH3 = 2'd3;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } slot_state_e;

  function automatic logic [NUM_CH-1:0] sel_decode(input sel_t sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice for a single demux channel, with a delivered-word
// counter that wraps and can be synchronously cleared.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned Width = 2,
  parameter int unsigned CntW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  input  logic             cnt_clr_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  cnt_o
);

  slot_state_e      state_q, state_d;
  logic [Width-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             deliver;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load while full only arrives when the slot is also delivering (reload).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (load_i) state_d = StFull;
      StFull:  if (!load_i && ready_i) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    valid_o = (state_q == StFull);
    deliver = valid_o & ready_i;
    data_o  = data_q;
    cnt_o   = cnt_q;
  end

  always_comb begin
    data_d = load_i ? data_i : data_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (deliver) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: rtl/demux_stream_1x4.sv
// 1-to-4 stream demultiplexer: steers each accepted word into the slot chosen by in_sel.
// Only the select decode and the in_ready mux live here; buffering is in demux_slot.
module demux_stream_1x4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  input  logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

  logic              accept;
  logic [NUM_CH-1:0] load;

  // in_ready deliberately has no dependency on in_valid.
  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    load     = accept ? sel_decode(in_sel) : '0;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .Width(WIDTH),
      .CntW (CNT_W)
    ) u_slot (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .load_i   (load[k]),
      .data_i   (in_data),
      .ready_i  (out_ready[k]),
      .cnt_clr_i(cnt_clr),
      .valid_o  (out_valid[k]),
      .data_o   (out_data[k*WIDTH +: WIDTH]),
      .cnt_o    (xfer_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_stream_1x4.sv
// Directed plus random bench for demux_stream_1x4 against a queue-based channel model.
module tb_demux_stream_1x4;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [1:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic        cnt_clr;
  logic [31:0] xfer_cnt;

  demux_stream_1x4 #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cnt_clr  (cnt_clr),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Model: words accepted but not yet delivered per channel, last word seen, delivered count.
  logic [1:0] mq[4][$];
  logic [1:0] mlast[4];
  int         mcnt[4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_in_ready();
    return (mq[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mlast[k] = 2'b00;
      mcnt[k]  = 0;
    end
  endtask

  task automatic check_all();
    logic [3:0]  ev;
    logic [7:0]  ed;
    logic [31:0] ec;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = (mq[k].size() != 0);
      ed[k*2 +: 2]   = (mq[k].size() != 0) ? mq[k][0] : mlast[k];
      ec[k*8 +: 8]   = 8'(mcnt[k]);
    end
    check("in_ready", 64'(in_ready), 64'(m_in_ready()));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data", 64'(out_data), 64'(ed));
    check("xfer_cnt", 64'(xfer_cnt), 64'(ec));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic       acc;
    logic [3:0] del;
    #3;
    check_all();
    acc = in_valid && m_in_ready();
    for (int k = 0; k < 4; k++) del[k] = (mq[k].size() != 0) && out_ready[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (del[k]) void'(mq[k].pop_front());
      if (cnt_clr) mcnt[k] = 0;
      else if (del[k]) mcnt[k] = (mcnt[k] + 1) % 256;
    end
    if (acc) begin
      mq[in_sel].push_back(in_data);
      mlast[in_sel] = in_data;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 2'd0;
    out_ready = 4'h0;
    cnt_clr   = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_out_data", 64'(out_data), 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    step();

    // Route one word to each channel.
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 2'(i + 1);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("route_cnt", 64'(xfer_cnt), 64'h01010101);

    // Stall channel 1, then route around it to channel 3.
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 2'b10;
    step();
    in_data = 2'b01;
    #1 check("stall_ready", 64'(in_ready), 64'h0);
    step();
    in_sel  = 2'd3;
    in_data = 2'b11;
    #1 check("bypass_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    #1 check("bypass_valid3", 64'(out_valid[3]), 64'h1);
    check("bypass_data3", 64'(out_data[7:6]), 64'h3);
    check("stall_held1", 64'(out_data[3:2]), 64'h2);
    step();
    out_ready = 4'hF;
    step();

    // Reload channel 0 with no bubble.
    out_ready = 4'b1110;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 2'b01;
    step();
    out_ready = 4'hF;
    in_data   = 2'b11;
    #1 check("reload_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    #1 check("reload_valid0", 64'(out_valid[0]), 64'h1);
    check("reload_data0", 64'(out_data[1:0]), 64'h3);
    step();
    step();

    // Asynchronous reset while slot 2 holds a word.
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 2'b10;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_cnt", 64'(xfer_cnt), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ready", 64'(in_ready), 64'h1);
    step();

    // 256 deliveries on channel 2 wrap its counter to zero.
    out_ready = 4'hF;
    cnt_clr   = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'd2;
      in_data  = 2'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("wrap_cnt2", 64'(xfer_cnt[23:16]), 64'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    #1 check("clr_deliver_valid", 64'(out_valid[2]), 64'h1);
    step();
    cnt_clr = 1'b0;
    #1 check("clr_wins_cnt2", 64'(xfer_cnt[23:16]), 64'h0);
    step();

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 2'($urandom_range(0, 3));
      out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      cnt_clr   = ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 4'hF;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
